// File: rtl/instr_fetch_decode.sv
// Sequential MIPS instruction fetch/decode engine: walks memory from a base
// address, splits each word into R/I/J fields, and hands them out on valid/ready.
module instr_fetch_decode #(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] count,
  output logic [31:0]      mem_addr,
  output logic             mem_read,
  input  logic [31:0]      mem_data,
  output logic             ins_valid,
  input  logic             ins_ready,
  output logic [31:0]      ins_word,
  output logic [31:0]      ins_pc,
  output logic [1:0]       ins_type,
  output logic [5:0]       opcode,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       shamt,
  output logic [5:0]       funct,
  output logic [31:0]      imm_sext,
  output logic [25:0]      target,
  output logic             busy,
  output logic             done
);

  localparam int unsigned LAT_W = 4;

  localparam logic [1:0] TYPE_R = 2'd0;
  localparam logic [1:0] TYPE_I = 2'd1;
  localparam logic [1:0] TYPE_J = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT,
    S_DONE
  } state_t;

  state_t           state, next_state;
  logic [31:0]      pc, pc_nxt;
  logic [CNT_W-1:0] remaining, rem_nxt;
  logic [LAT_W-1:0] lat_cnt, lat_nxt;
  logic             capture;
  logic             done_nxt;

  // Word-alignment bits of base_addr are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^base_addr[1:0];

  function automatic logic [1:0] classify(input logic [5:0] op);
    if (op == 6'd0)                      return TYPE_R;
    else if (op == 6'd2 || op == 6'd3)   return TYPE_J;
    else                                 return TYPE_I;
  endfunction

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state and datapath update decisions
  always_comb begin
    next_state = state;
    pc_nxt     = pc;
    rem_nxt    = remaining;
    lat_nxt    = lat_cnt;
    capture    = 1'b0;
    done_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (count != '0) begin
            pc_nxt     = {base_addr[31:2], 2'b00};
            rem_nxt    = count;
            next_state = S_REQ;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      S_REQ: begin
        lat_nxt    = LAT_W'(MEM_LAT - 1);
        next_state = S_WAIT;
      end
      S_WAIT: begin
        if (lat_cnt == '0) begin
          capture    = 1'b1;
          next_state = S_OUT;
        end else begin
          lat_nxt = lat_cnt - LAT_W'(1);
        end
      end
      S_OUT: begin
        if (ins_ready) begin
          pc_nxt  = pc + 32'd4;
          rem_nxt = remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            next_state = S_DONE;
            done_nxt   = 1'b1;
          end else begin
            next_state = S_REQ;
          end
        end
      end
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Registered outputs are derived from the upcoming state so they align with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= '0;
      remaining <= '0;
      lat_cnt   <= '0;
      mem_read  <= 1'b0;
      mem_addr  <= '0;
      ins_valid <= 1'b0;
      ins_word  <= '0;
      ins_pc    <= '0;
      ins_type  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      pc        <= pc_nxt;
      remaining <= rem_nxt;
      lat_cnt   <= lat_nxt;
      mem_read  <= (next_state == S_REQ);
      if (next_state == S_REQ) mem_addr <= pc_nxt;
      ins_valid <= (next_state == S_OUT);
      busy      <= (next_state != S_IDLE);
      done      <= done_nxt;
      if (capture) begin
        ins_word <= mem_data;
        ins_pc   <= pc;
        ins_type <= classify(mem_data[31:26]);
      end
    end
  end

  assign opcode   = ins_word[31:26];
  assign rs       = ins_word[25:21];
  assign rt       = ins_word[20:16];
  assign rd       = ins_word[15:11];
  assign shamt    = ins_word[10:6];
  assign funct    = ins_word[5:0];
  assign imm_sext = {{16{ins_word[15]}}, ins_word[15:0]};
  assign target   = ins_word[25:0];

endmodule

// File: doc/instr_fetch_decode.md
Name: instr_fetch_decode

Overview:
Sequential fetch-and-decode engine for the MIPS 32-bit datapath. On a start pulse it walks instruction memory from a programmable word address for a programmable instruction count. Each word is read through a fixed-latency synchronous memory port and split into R/I/J fields. Decoded instructions are presented on a valid/ready output handshake, one at a time, with the PC of each instruction.

Parameters:
MEM_LAT, 1, memory read latency in cycles from the request cycle to data valid (legal 1..15)
CNT_W, 8, width of the instruction-count input and internal remaining counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  begin a fetch run; sampled only in IDLE
base_addr  input  32  byte address of the first instruction; bits [1:0] ignored (forced 0)
count  input  CNT_W  number of instructions to fetch
mem_addr  output  32  memory read address
mem_read  output  1  memory read strobe
mem_data  input  32  memory read data, valid MEM_LAT cycles after the request cycle
ins_valid  output  1  decoded instruction available
ins_ready  input  1  consumer accepts the instruction
ins_word  output  32  raw instruction
ins_pc  output  32  byte address of ins_word
ins_type  output  2  0=R (opcode 0), 1=I (all other opcodes), 2=J (opcode 2 or 3), 3 unused
opcode  output  6  ins_word[31:26]
rs, rt, rd  output  5 each  [25:21], [20:16], [15:11]
shamt  output  5  [10:6]
funct  output  6  [5:0]
imm_sext  output  32  [15:0] sign-extended
target  output  26  [25:0]
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse at the end of a run

Behaviour:
- Reset (asynchronous): state=IDLE. All outputs 0: mem_read, mem_addr, ins_valid, all field registers, busy, done. Internal pc and remaining counter also 0.
- Field outputs are combinational slices of the registered ins_word. ins_type is registered with ins_word.
- IDLE: on start=1 with count!=0, latch pc={base_addr[31:2],2'b00} and remaining=count, go to REQ. On start=1 with count=0, pulse done for one cycle and stay in IDLE.
- REQ (1 cycle): mem_read=1, mem_addr=pc. Load the latency counter with MEM_LAT-1, then go to WAIT.
- WAIT: mem_read=0 and mem_addr holds its value. Decrement the latency counter each cycle. In the cycle the counter is 0, capture mem_data into ins_word, set ins_pc=pc, and go to OUT.
- Timing: a request in cycle T means mem_data is sampled at the end of cycle T+MEM_LAT, and ins_valid rises in cycle T+MEM_LAT+1.
- OUT: ins_valid=1. ins_word and all fields are stable until the handshake.
  - On ins_valid&&ins_ready: pc=pc+4 (wraps modulo 2^32, 0xFFFFFFFC→0) and remaining decrements.
  - If remaining was 1, go to DONE; otherwise go to REQ.
  - ins_valid drops in the cycle after acceptance.
- Throughput with ins_ready held high: one instruction every MEM_LAT+2 cycles.
- DONE (1 cycle): done=1, busy=1, then go to IDLE. ins_word retains the last instruction.
- start asserted while busy is ignored: no restart and no latch of base_addr or count.
- ins_ready while ins_valid=0 has no effect.
- Reset mid-run aborts immediately: ins_valid drops asynchronously and the run does not resume.
- Only one memory request is outstanding at any time.

Test Plan:
- MEM_LAT=1; memory holds 0x012A4020 @128, 0x8D280004 @132, 0x08000020 @136; start, base_addr=128, count=3, ready=1 → three handshakes:
  - type R: rs=9, rt=10, rd=8, funct=32, pc=128
  - type I: opcode=35, rs=9, rt=8, imm_sext=4, pc=132
  - type J: target=32, pc=136
  - then a done pulse; ins_valid rises 2 cycles after each mem_read.
- Backpressure: count=2, ins_ready low for 5 cycles on the first instruction → ins_word and ins_pc stay constant, no second mem_read until acceptance.
- MEM_LAT=3: instruction 0x2008FFFF → imm_sext=0xFFFFFFFF, ins_valid rises exactly 4 cycles after the mem_read cycle.
- count=0 start → done pulses one cycle, busy and mem_read never assert. start pulsed mid-run with base_addr=0 → ignored, addresses continue +4.
- Wrap: base_addr=0xFFFFFFFE, count=2 → ins_pc=0xFFFFFFFC then 0x00000000.
- Reset asserted in WAIT → same-cycle outputs all 0, state IDLE. A following start with count=1 completes normally.
